// File: rtl/pmu_pkg.sv
// Shared types and constants for the PMU stream engine: FSM states, mode encoding, default sizes.
package pmu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } pmu_state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int PMU_NUM_LANES  = 240;
  localparam int PMU_DATA_WIDTH = 16;

endpackage

// File: rtl/pmu_lane_alu.sv
// One combinational PMU lane: zero-extended add, or subtract with the MSB as borrow.
module pmu_lane_alu
  import pmu_pkg::*;
#(
  parameter  int DATA_WIDTH = PMU_DATA_WIDTH,
  localparam int OUT_W      = DATA_WIDTH + 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic [OUT_W-1:0]      y
);

  always_comb begin
    if (sub == MODE_SUB) y = {1'b0, a} - {1'b0, b};
    else                 y = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/pmu_stream_engine.sv
// Load / parallel compute / drain engine around NUM_LANES PMU lane adders.
// Optional PMU_OUT_LAST_EN adds an out_last marker on the final drained beat.
module pmu_stream_engine
  import pmu_pkg::*;
#(
  parameter  int NUM_LANES  = PMU_NUM_LANES,
  parameter  int DATA_WIDTH = PMU_DATA_WIDTH,
  localparam int OUT_W      = DATA_WIDTH + 1,
  localparam int CNT_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [CNT_W-1:0]      lane_count,
  output logic                  busy,
  output logic                  batch_done
`ifdef PMU_OUT_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  pmu_state_e          state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                batch_done_q;
  logic [CNT_W-1:0]    lane_count_q;
  logic [CNT_W-1:0]    rd_idx_q;
  logic                mode_q;
`ifdef PMU_OUT_LAST_EN
  logic                out_last_q;
`endif

  logic [DATA_WIDTH-1:0] a_q      [NUM_LANES];
  logic [DATA_WIDTH-1:0] b_q      [NUM_LANES];
  logic [OUT_W-1:0]      result_q [NUM_LANES];
  logic [OUT_W-1:0]      alu_y    [NUM_LANES];

  logic             accept;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] last_idx;

  // in_ready_q is only ever high in IDLE/LOAD, so accept never fires elsewhere.
  assign accept   = in_valid && in_ready_q;
  assign wr_idx   = (state_q == IDLE) ? '0 : lane_count_q;
  assign last_idx = lane_count_q - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q[wr_idx[IDX_W-1:0]] <= in_a;
      b_q[wr_idx[IDX_W-1:0]] <= in_b;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pmu_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a   (a_q[gi]),
        .b   (b_q[gi]),
        .sub (mode_q),
        .y   (alu_y[gi])
      );
    end
  endgenerate

  // Stale lanes beyond lane_count are computed too but never drained.
  always_ff @(posedge clk) begin
    if (state_q == COMPUTE) result_q <= alu_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      lane_count_q <= '0;
      rd_idx_q     <= '0;
      mode_q       <= MODE_ADD;
`ifdef PMU_OUT_LAST_EN
      out_last_q   <= 1'b0;
`endif
    end else begin
      batch_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            lane_count_q <= CNT_W'(1);
            mode_q       <= mode_sub;
            if (in_last) begin
              state_q    <= COMPUTE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            lane_count_q <= lane_count_q + CNT_W'(1);
            if (in_last || (lane_count_q == CNT_W'(NUM_LANES - 1))) begin
              state_q    <= COMPUTE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          state_q     <= DRAIN;
          out_valid_q <= 1'b1;
          rd_idx_q    <= '0;
`ifdef PMU_OUT_LAST_EN
          out_last_q  <= (lane_count_q == CNT_W'(1));
`endif
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx_q == last_idx) begin
              state_q      <= IDLE;
              out_valid_q  <= 1'b0;
              busy_q       <= 1'b0;
              batch_done_q <= 1'b1;
              in_ready_q   <= 1'b1;
              rd_idx_q     <= '0;
`ifdef PMU_OUT_LAST_EN
              out_last_q   <= 1'b0;
`endif
            end else begin
              rd_idx_q   <= rd_idx_q + CNT_W'(1);
`ifdef PMU_OUT_LAST_EN
              out_last_q <= ((rd_idx_q + CNT_W'(1)) == last_idx);
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? result_q[rd_idx_q[IDX_W-1:0]] : '0;
  assign lane_count = lane_count_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;
`ifdef PMU_OUT_LAST_EN
  assign out_last   = out_last_q;
`endif

endmodule

// File: tb/tb_pmu_stream_engine.sv
// Directed bench for pmu_stream_engine: add/sub batches, full batch, backpressure, reset abort.
module tb_pmu_stream_engine;

  localparam int NL = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] out_data;
  logic [7:0]  lane_count;
  logic        busy;
  logic        batch_done;
`ifdef PMU_OUT_LAST_EN
  logic        out_last;
  logic        last_q[$];
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int rdy_viol = 0;
  bit rand_rdy = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  pmu_stream_engine dut (
    .clk        (clk),
    .rst        (rst),
    .mode_sub   (mode_sub),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lane_count (lane_count),
    .busy       (busy),
    .batch_done (batch_done)
`ifdef PMU_OUT_LAST_EN
    ,
    .out_last   (out_last)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge view predicts the next edge's handshakes.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(32'(out_data));
`ifdef PMU_OUT_LAST_EN
      last_q.push_back(out_last);
`endif
    end
    if (batch_done) done_cnt++;
    if (busy && in_ready) rdy_viol++;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last,
                           input logic msub, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last; mode_sub = msub;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 500) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int n;
    n0 = done_cnt;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (done_cnt != n0) break;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt - n0), 32'd1);
  endtask

  task automatic expect_results(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int n0;
    logic [15:0] ra, rb;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_batch_done", 32'(batch_done), 32'd0);
    check("rst_lane_count", 32'(lane_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Add batch, 4 lanes, with latency checks
    got_q.delete();
    send_beat(16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
    send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat(16'd100, 16'd28, 1'b0, 1'b0, 1'b0);
    send_beat(16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    check("add_compute_busy", 32'(busy), 32'd1);
    check("add_compute_in_ready", 32'(in_ready), 32'd0);
    check("add_compute_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("add_first_out_valid", 32'(out_valid), 32'd1);
    check("add_lane_count", 32'(lane_count), 32'd4);
    wait_done("add");
    exp_q = {32'd3, 32'h1FFFE, 32'd128, 32'd0};
    expect_results("add");

    // Subtract batch, mode toggled mid-batch
    got_q.delete();
    send_beat(16'd5, 16'd3, 1'b0, 1'b1, 1'b0);
    send_beat(16'd3, 16'd5, 1'b1, 1'b0, 1'b0);
    wait_done("sub");
    exp_q = {32'd2, 32'h1FFFE};
    expect_results("sub");

    // Full batch without in_last
    got_q.delete();
    exp_q.delete();
    rdy_viol = 0;
    for (int i = 0; i < NL; i++) begin
      send_beat(16'(i), 16'(i), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'(2 * i));
    end
    check("full_compute_busy", 32'(busy), 32'd1);
    check("full_lane_count", 32'(lane_count), 32'(NL));
    wait_done("full");
    expect_results("full");
    check("full_ready_while_busy", 32'(rdy_viol), 32'd0);

    // Backpressure on lane 1
    got_q.delete();
    out_ready = 1'b0;
    send_beat(16'd10, 16'd0, 1'b0, 1'b0, 1'b0);
    send_beat(16'd20, 16'd0, 1'b0, 1'b0, 1'b0);
    send_beat(16'd30, 16'd0, 1'b0, 1'b0, 1'b0);
    send_beat(16'd40, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    check("bp_lane0", 32'(out_data), 32'd10);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {14'd0, out_valid, out_data}, {14'd0, 1'b1, 17'd20});
    end
    out_ready = 1'b1;
    wait_done("bp");
    exp_q = {32'd10, 32'd20, 32'd30, 32'd40};
    expect_results("bp");

    // Random gaps on both sides over 17 lanes
    got_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      exp_q.push_back(32'({1'b0, ra} + {1'b0, rb}));
      send_beat(ra, rb, (i == 16), 1'b0, 1'b1);
    end
    wait_done("rand");
    rand_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    expect_results("rand");

    // Reset mid-drain after 2 of 5 results
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(16'(i + 1), 16'd1, (i == 4), 1'b0, 1'b0);
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    n0 = done_cnt;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_results_seen", 32'(got_q.size()), 32'd2);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_lane_count", 32'(lane_count), 32'd0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - n0), 32'd0);
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    got_q.delete();
    send_beat(16'd7, 16'd9, 1'b1, 1'b0, 1'b0);
    wait_done("one");
    exp_q = {32'd16};
    expect_results("one");

`ifdef PMU_OUT_LAST_EN
    got_q.delete();
    last_q.delete();
    for (int i = 0; i < 3; i++) send_beat(16'(i), 16'd0, (i == 2), 1'b0, 1'b0);
    wait_done("last");
    check("last_count", 32'(last_q.size()), 32'd3);
    if (last_q.size() == 3)
      check("last_flags", {29'd0, last_q[0], last_q[1], last_q[2]}, 32'b001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
